uart_rx_frontend: RTL

//  8-bit asynchronous serial receiver feeding the MIPS micro-system UART peripheral from the board pin.

---
 rtl/uart_rx_frontend.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver: 2-FF synchronizer, mid-bit sampling, one-entry byte buffer with sticky flags.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_frontend #(
    parameter int CLK_PER_BIT = 325,
    parameter int HALF_BIT    = CLK_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLK_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rxd_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          half_hit, full_hit, good, fe_set;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
    logic          pe_set;
`endif

    assign half_hit = (cnt_q == CW'(HALF_BIT - 1));
    assign full_hit = (cnt_q == CW'(CLK_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        good    = 1'b0;
        fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_set  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q) state_d = START;
            end
            START: begin
                if (half_hit) begin
                    cnt_d = '0;
                    bit_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_d = 1'b0;
`endif
                    // A high line at mid start bit is a glitch, not a frame.
                    state_d = rxd_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_hit) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    par_d   = par_q ^ rxd_s_q;
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_hit) begin
                    cnt_d   = '0;
                    pe_set  = par_q ^ rxd_s_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (full_hit) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        good    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxd_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Clear on rd_ack first, then let same-cycle set events win.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (rd_ack) begin
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
        if (good) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_ack) overrun_d = 1'b1;
        end
        if (fe_set) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (pe_set) parity_err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            rxd_s_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
